// File: rtl/shift_cmd_queue.sv
// Command queue feeding a barrel shifter: buffers {data, shift_amt, direction}
// in a small circular FIFO and issues one entry per GAP+1 cycles as a one-cycle strobe.
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int GAP   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [4:0]               in_shift_amt,
  input  logic                     in_direction,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [4:0]               out_shift_amt,
  output logic                     out_direction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]       GAP_C   = 4'(GAP);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shift_amt;
    logic        direction;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       gap_cnt;
  logic             push;
  logic             issue;

  // Ready depends on registered occupancy only, so a full queue never bypasses.
  assign in_ready = (count < DEPTH_C);

  always_comb begin
    push  = in_valid && in_ready;
    issue = (count != '0) && (gap_cnt == 4'd0);
    head  = mem[rd_ptr];
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count alone, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: in_data, shift_amt: in_shift_amt, direction: in_direction};
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, e.g. issue sees count before this edge's push.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_shift_amt <= '0;
      out_direction <= 1'b0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      gap_cnt       <= '0;
    end else if (flush) begin
      // Issued fields keep their last values; only queue state is cleared.
      out_valid <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_data      <= head.data;
        out_shift_amt <= head.shift_amt;
        out_direction <= head.direction;
        rd_ptr        <= rd_ptr + PTR_W'(1);
        gap_cnt       <= GAP_C;
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/shift_cmd_queue.md
SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of command entries (power of two, at least 2).
REQ-002 Parameter: GAP, 3, minimum number of idle cycles between consecutive issues (0 to 15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  upstream command present.
- in_ready  out  1  queue can accept.
- in_data  in  32  operand.
- in_shift_amt  in  5  shift amount.
- in_direction  in  1  0 = left, 1 = right.
- out_valid  out  1  one-cycle issue strobe to the barrel shifter's valid_in.
- out_data  out  32  issued operand.
- out_shift_amt  out  5  issued amount.
- out_direction  out  1  issued direction.
- count  out  $clog2(DEPTH)+1  occupancy.

Function
REQ-005 The queue SHALL store {in_data, in_shift_amt, in_direction} as one 38-bit entry in a DEPTH-entry circular FIFO.
- Read and write pointers wrap modulo DEPTH.
REQ-006 in_ready SHALL equal (count < DEPTH).
- It is combinational from registered count only.
- There is no same-cycle bypass when full.
REQ-007 Push SHALL occur on a rising edge where in_valid && in_ready.
- Upstream holds all in_* stable while in_valid && !in_ready.
REQ-008 A 4-bit gap counter gap_cnt SHALL decrement by 1 on each edge where it is nonzero.
REQ-009 Issue SHALL occur on an edge where count != 0 and gap_cnt == 0. On that edge:
- the head entry is registered onto out_data/out_shift_amt/out_direction;
- out_valid is set to 1;
- the head entry is popped;
- gap_cnt is loaded with GAP.
REQ-010 out_valid SHALL be 0 after every edge without an issue, so it is never high for two consecutive cycles when GAP > 0.
REQ-011 Consecutive issues SHALL be exactly GAP+1 cycles apart while the queue stays non-empty.
REQ-012 out_data/out_shift_amt/out_direction SHALL hold the last issued values while out_valid is 0.
REQ-013 Minimum latency SHALL be 1 cycle.
- A push at edge k into an empty queue with gap_cnt == 0 gives out_valid high after edge k+1.
- The entry is never issued on the same edge it is written.
REQ-014 A simultaneous push and issue on one edge SHALL leave count unchanged and preserve FIFO order.
REQ-015 Commands SHALL be issued strictly in acceptance order, with no loss or duplication.
REQ-016 count SHALL equal pushes minus pops since the last reset or flush, and SHALL never exceed DEPTH or underflow.
REQ-017 flush SHALL take priority over push and issue on the same edge. On that edge it:
- empties the queue (count = 0, pointers = 0);
- clears gap_cnt to 0;
- forces out_valid to 0;
- leaves out_data/out_shift_amt/out_direction unchanged;
- drops the concurrent push.
REQ-018 Commands whose shift_amt is 0 SHALL be queued and issued like any other command, with no special casing.

Reset
REQ-019 On an edge with rst = 1, the block SHALL set:
- out_valid = 0;
- out_data = 0, out_shift_amt = 0, out_direction = 0;
- count = 0, both pointers = 0, gap_cnt = 0.
REQ-020 rst SHALL take priority over flush, push and issue.
- Reset mid-burst discards all stored commands.
- in_ready is 1 from the first edge after rst deasserts.
REQ-021 Stored FIFO entries SHALL NOT require reset.

Verification (DEPTH = 4, GAP = 3)
REQ-022 Reset: hold rst = 1 for 2 edges -> out_valid = 0, out_data = 0x00000000, count = 0, in_ready = 1.
REQ-023 Single command: push {0xA5A5A5A5, 2, 0} at edge k -> out_valid = 1 for exactly one cycle after edge k+1, out_data = 0xA5A5A5A5, out_shift_amt = 2, out_direction = 0; count returns to 0.
REQ-024 Burst: hold in_valid with 6 distinct commands from edge 1. Required response:
- in_ready drops after the 5th acceptance (edge 5, count = 4);
- issues occur at edges 2, 6, 10, 14, 18, 22 in push order;
- count is never greater than 4.
REQ-025 Full backpressure: fill 4 entries during a gap window -> in_ready = 0, a held 5th command is accepted on the edge after the next issue, and order is preserved.
REQ-026 Flush: queue 3 commands, then assert flush on an edge that coincides with a push and an eligible issue -> count = 0, out_valid = 0 next cycle, no later out_valid until a new push; the next push issues after 1 cycle.
REQ-027 Reset mid-burst: assert rst with count = 3 and gap_cnt = 2 -> all outputs are at reset values; after release, a push of {0x0000FFFF, 4, 1} issues 1 cycle later with exactly those fields.
